fetch_pc: RTL and testbench
===========================

# fetch_pc

Program-counter and fetch-sequencing stage feeding the 9-bit instruction memory, upstream of decode and the 8-bit ALU. It holds the PC, advances it once per executed instruction, and redirects it when a branch is taken on the ALU `isZero` flag. It also runs a start/halt/done handshake with the testbench or top level, and keeps a saturating count of executed instructions.

## Interface

Parameters:
- `PC_W`, default 10: PC width; the instruction memory depth is 2^PC_W.
- `START_ADDR`, default 0: PC value loaded on reset and on every accepted `start`.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request to begin or restart execution; sampled in IDLE and DONE.
- `stall`, input, 1: freezes the PC and counter for this cycle.
- `halt_req`, input, 1: asserted by decode when the current instruction is HALT.
- `branch_en`, input, 1: the current instruction is a conditional branch.
- `is_zero`, input, 1: ALU branch-condition flag for the current instruction.
- `rel_en`, input, 1: 1 means `target` is a signed relative offset; 0 means it is an absolute address.
- `target`, input, PC_W: branch offset or address.
- `pc`, output, PC_W: current instruction address, registered.
- `fetch_valid`, output, 1: `pc` addresses an instruction being executed this cycle.
- `done`, output, 1: the program has halted, registered.
- `instr_cnt`, output, 16: number of executed instructions, registered and saturating.

## Operation

States are IDLE, RUN and DONE. Reset forces IDLE from any state, including mid-RUN.

IDLE:
- `pc` = START_ADDR, `done` = 0, `fetch_valid` = 0; `instr_cnt` holds its value.
- `start` = 1 causes: next state RUN, `pc` = START_ADDR, `instr_cnt` = 0.

RUN:
- `fetch_valid` = 1 for every RUN cycle, including stalled ones.
- Update priority per cycle is stall > halt > branch > increment:
  - `stall` = 1: `pc`, `instr_cnt` and the state all hold; `halt_req` and `branch_en` are ignored for this cycle.
  - `halt_req` = 1: next state DONE, `pc` holds (still points at the HALT instruction), `instr_cnt` +1.
  - `branch_en` & `is_zero`, with `rel_en` = 1: `pc` = `pc` + `target`. `target` is two's complement; the add is modulo 2^PC_W.
  - `branch_en` & `is_zero`, with `rel_en` = 0: `pc` = `target`.
  - Otherwise: `pc` = `pc` + 1, modulo 2^PC_W, so the maximum address wraps to 0.
  - Every non-halt, non-stalled cycle also does `instr_cnt` +1.
- `instr_cnt` saturates at 16'hFFFF and does not wrap.
- `start` is ignored in RUN.

DONE:
- `done` = 1, `fetch_valid` = 0; `pc` and `instr_cnt` hold.
- `start` = 1 causes: next state RUN, `pc` = START_ADDR, `instr_cnt` = 0, and `done` = 0 on the same edge.

Reset values: state IDLE, `pc` = START_ADDR, `done` = 0, `fetch_valid` = 0, `instr_cnt` = 0.

## Timing

- `pc`, `done` and `instr_cnt` are registered.
- `fetch_valid` is decoded combinationally from the state register only, so it has no path from any input.
- Start latency: `start` sampled at edge N gives `pc` = START_ADDR and `fetch_valid` = 1 in cycle N+1.
- Branch and increment: the decision made in cycle N appears on `pc` after edge N+1. There is no delay slot; redirect penalty is 0 cycles.
- Halt: `halt_req` sampled at edge N gives `done` = 1 and `fetch_valid` = 0 from cycle N+1.
- `reset` overrides every input on the same edge.
- `branch_en`/`is_zero`/`target` must be stable before the edge; they come from the ALU combinationally.

## Test plan

- Reset, then `start` pulse, 5 plain cycles: `pc` steps 0,1,2,3,4,5; `fetch_valid` = 1; `instr_cnt` = 5.
- At `pc` = 4, `branch_en` = 1, `is_zero` = 1, `rel_en` = 1, `target` = 10'h3FE (-2): next `pc` = 2. Repeat with `is_zero` = 0: next `pc` = 5. With `rel_en` = 0 and `target` = 10'h155: next `pc` = 10'h155.
- Wrap: absolute branch to 10'h3FF, then plain cycle: `pc` = 0. Relative offset +3 from 10'h3FE: `pc` = 1.
- `stall` for 3 cycles at `pc` = 7 with `halt_req` and a taken branch also asserted: `pc` stays 7, `instr_cnt` unchanged, state stays RUN. Release stall with `halt_req` = 1: `done` = 1 next cycle, `pc` = 7, `fetch_valid` = 0.
- Restart from DONE: `start` pulse gives `pc` = 0, `done` = 0, `instr_cnt` = 0. `start` asserted during RUN has no effect.
- `reset` asserted mid-RUN at `pc` = 9: next cycle state IDLE, `pc` = 0, `done` = 0, `fetch_valid` = 0. Separately, run 65540 non-stalled cycles: `instr_cnt` = 16'hFFFF.

Source files
------------

// File: rtl/fetch_pc.sv
// fetch_pc: program counter and fetch sequencing with a start/halt/done
// handshake and a saturating count of executed instructions.
module fetch_pc #(
    parameter int unsigned          PC_W       = 10,
    parameter logic [PC_W-1:0]      START_ADDR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            branch_en,
    input  logic            is_zero,
    input  logic            rel_en,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic            done,
    output logic [15:0]     instr_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic              r_done;
    logic [15:0]       r_cnt;

    state_t            w_state_nxt;
    logic [PC_W-1:0]   w_pc_nxt;
    logic              w_done_nxt;
    logic [15:0]       w_cnt_nxt;
    logic [15:0]       w_cnt_inc;
    logic              w_taken;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_taken   = branch_en & is_zero;

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= START_ADDR;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and next-value decode; priority in RUN is stall > halt > branch > increment.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_done_nxt  = r_done;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_pc_nxt   = START_ADDR;
                w_done_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (halt_req) begin
                        // PC stays on the HALT instruction.
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else if (w_taken) begin
                        w_pc_nxt = rel_en ? (r_pc + target) : target;
                    end else begin
                        w_pc_nxt = r_pc + PC_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = START_ADDR;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = START_ADDR;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    assign pc          = r_pc;
    assign done        = r_done;
    assign instr_cnt   = r_cnt;
    assign fetch_valid = (r_state == S_RUN);

endmodule

// File: tb/tb_fetch_pc.sv
// Scoreboard bench for fetch_pc: each scenario pushes the expected
// {pc, fetch_valid, done, instr_cnt} before a clock and compares after it.
module tb_fetch_pc;

    localparam int unsigned PC_W = 10;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            fv;
        logic            dn;
        logic [15:0]     cnt;
    } obs_t;

    logic            clk = 1'b0;
    logic            reset, start, stall, halt_req, branch_en, is_zero, rel_en;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc;
    logic            fetch_valid, done;
    logic [15:0]     instr_cnt;

    obs_t sb[$];
    obs_t e, got;
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_pc #(.PC_W(PC_W), .START_ADDR(10'd0)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .halt_req(halt_req), .branch_en(branch_en), .is_zero(is_zero),
        .rel_en(rel_en), .target(target), .pc(pc), .fetch_valid(fetch_valid),
        .done(done), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        got = '{pc: pc, fv: fetch_valid, dn: done, cnt: instr_cnt};
    endtask

    task automatic set_in(input logic st, input logic sl, input logic h, input logic b,
                          input logic z, input logic r, input logic [PC_W-1:0] t);
        start = st; stall = sl; halt_req = h; branch_en = b; is_zero = z; rel_en = r; target = t;
    endtask

    function automatic obs_t mk(input logic [PC_W-1:0] p, input logic f, input logic d,
                                input logic [15:0] c);
        return '{pc: p, fv: f, dn: d, cnt: c};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        sb.push_back(mk(10'd0, 1'b0, 1'b0, 16'd0));
        tick();
        tick();
        e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", got, e);
        end
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        sb.push_back(mk(10'd0, 1'b0, 1'b0, 16'd0));
        tick();
        e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL idle_hold: got %h expected %h", got, e);
        end
    endtask

    task automatic test_plain();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        sb.push_back(mk(10'd0, 1'b1, 1'b0, 16'd0));
        tick();
        start = 1'b0;
        e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL start_latency: got %h expected %h", got, e);
        end
        for (int i = 1; i <= 5; i++) begin
            sb.push_back(mk(PC_W'(i), 1'b1, 1'b0, 16'(i)));
            tick();
            e = sb.pop_front(); n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL plain_step%0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    // Rows: branch_en, is_zero, rel_en, target, expected pc; count rises by one per row.
    task automatic test_branch();
        logic [PC_W:0] t_b[8] = '{11'h000, 11'h000, 11'h000, 11'h000,
                                  11'h000, 11'h000, 11'h000, 11'h000};
        logic [PC_W-1:0] tgt[8]  = '{10'd4, 10'h3FE, 10'd4, 10'h3FE, 10'h155, 10'h3FF, 10'd0,  10'h3FE};
        logic [PC_W-1:0] expc[8] = '{10'd4, 10'd2,   10'd4, 10'd5,   10'h155, 10'h3FF, 10'd0,  10'h3FE};
        logic            b[8]    = '{1'b1,  1'b1,    1'b1,  1'b1,    1'b1,    1'b1,    1'b0,   1'b1};
        logic            z[8]    = '{1'b1,  1'b1,    1'b1,  1'b0,    1'b1,    1'b1,    1'b0,   1'b1};
        logic            r[8]    = '{1'b0,  1'b1,    1'b0,  1'b1,    1'b0,    1'b0,    1'b0,   1'b0};
        t_b[0] = '0;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 1'b0, 1'b0, b[i], z[i], r[i], tgt[i]);
            sb.push_back(mk(expc[i], 1'b1, 1'b0, 16'(6 + i)));
            tick();
            e = sb.pop_front(); n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL branch_row%0d: got %h expected %h", i, got, e);
            end
        end
        // Relative +3 from 3FE wraps to 1.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd3);
        sb.push_back(mk(10'd1, 1'b1, 1'b0, 16'd14));
        tick();
        e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL rel_wrap: got %h expected %h", got, e);
        end
    endtask

    task automatic test_stall_halt();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd7);
        sb.push_back(mk(10'd7, 1'b1, 1'b0, 16'd15));
        tick();
        e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL goto7: got %h expected %h", got, e);
        end
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'h055);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(10'd7, 1'b1, 1'b0, 16'd15));
            tick();
            e = sb.pop_front(); n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL stall%0d: got %h expected %h", i, got, e);
            end
        end
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        sb.push_back(mk(10'd7, 1'b0, 1'b1, 16'd16));
        tick();
        e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL halt: got %h expected %h", got, e);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h0AA);
        sb.push_back(mk(10'd7, 1'b0, 1'b1, 16'd16));
        tick();
        e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL done_hold: got %h expected %h", got, e);
        end
    endtask

    task automatic test_restart();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        sb.push_back(mk(10'd0, 1'b1, 1'b0, 16'd0));
        for (int i = 1; i <= 9; i++) sb.push_back(mk(PC_W'(i), 1'b1, 1'b0, 16'(i)));
        for (int i = 0; i <= 9; i++) begin
            if (i == 3) start = 1'b0;
            tick();
            e = sb.pop_front(); n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL restart_step%0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        reset = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h123);
        sb.push_back(mk(10'd0, 1'b0, 1'b0, 16'd0));
        tick();
        e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL reset_mid_run: got %h expected %h", got, e);
        end
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_saturate();
        int bad = 0;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        start = 1'b0;
        for (int i = 1; i <= 65540; i++) begin
            sb.push_back(mk(PC_W'(i), 1'b1, 1'b0, (i > 65535) ? 16'hFFFF : 16'(i)));
            tick();
            e = sb.pop_front(); n_cmp++;
            if (got !== e) begin
                n_err++;
                if (bad < 5) $display("FAIL saturate_step%0d: got %h expected %h", i, got, e);
                bad++;
            end
        end
        halt_req = 1'b1;
        sb.push_back(mk(PC_W'(65540), 1'b0, 1'b1, 16'hFFFF));
        tick();
        halt_req = 1'b0;
        e = sb.pop_front(); n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL saturate_halt: got %h expected %h", got, e);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        test_reset();
        test_plain();
        test_branch();
        test_stall_halt();
        test_restart();
        test_reset_mid_run();
        test_saturate();
        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
